// File: rtl/pong_game_ctrl_if.sv
// Game-flow controller interface: frame/button/miss inputs toward the
// controller, renderer select, motion enables and scoreboard outputs back.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_pause;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] screen_sel;
    logic       ball_en;
    logic       paddle_en;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;

    // Stimulus side: drives frame tick, buttons and miss pulses.
    modport master (
        output frame_tick, btn_start, btn_pause, miss_left, miss_right,
        input  screen_sel, ball_en, paddle_en, serve_dir,
               score_l, score_r, winner
    );

    // Controller side.
    modport slave (
        input  frame_tick, btn_start, btn_pause, miss_left, miss_right,
        output screen_sel, ball_en, paddle_en, serve_dir,
               score_l, score_r, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller. Sequences start/serve/play/point/game-over,
// keeps both scores and drives renderer select plus ball/paddle enables.
// Optional pause state is compiled in when PONG_PAUSE_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_ATTRACT | start screen, scores cleared, waiting for start edge
// ST_SERVE   | paddles live, ball parked for SERVE_FRAMES frames
// ST_PLAY    | ball and paddles live, watching for misses
// ST_POINT   | everything frozen for POINT_FRAMES frames after a score
// ST_OVER    | game-over screen, scores and winner held
// ST_PAUSE   | (PONG_PAUSE_EN only) play frozen until next pause edge
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic              clk,
    input  logic              rst_n,
    pong_game_ctrl_if.slave   bus
);

    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LIM = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LIM = 8'(POINT_FRAMES);

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_FIELD = 2'b01;
    localparam logic [1:0] SEL_OVER  = 2'b10;
    localparam logic [1:0] SEL_PAUSE = 2'b11;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_POINT   = 3'd3,
        ST_OVER    = 3'd4
`ifdef PONG_PAUSE_EN
        ,ST_PAUSE  = 3'd5
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] frame_cnt;
    logic       start_prev;
    logic       pause_prev;
    logic       start_edge;
    logic [3:0] score_l_q;
    logic [3:0] score_r_q;
    logic [3:0] score_l_next;
    logic [3:0] score_r_next;
    logic       serve_dir_q;
    logic       serve_dir_next;
    logic [1:0] winner_q;
    logic [1:0] winner_next;
    logic       ball_en_q;
    logic       paddle_en_q;
    logic       ball_en_next;
    logic       paddle_en_next;
    logic [1:0] screen_sel_q;
    logic [1:0] screen_sel_cur;
    logic       l_won;
    logic       r_won;

`ifdef PONG_PAUSE_EN
    logic       pause_edge;
    assign pause_edge = bus.btn_pause & ~pause_prev;
`else
    // Pause button has no effect in this build; keep it visibly consumed.
    logic       unused_pause;
    assign unused_pause = bus.btn_pause ^ pause_prev;
`endif

    assign start_edge = bus.btn_start & ~start_prev;
    assign l_won      = (score_l_q >= WIN_LIM);
    assign r_won      = (score_r_q >= WIN_LIM);

    // Scores stop at the winning value even if both players miss together.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_LIM) ? s : s + 4'd1;
    endfunction

    // Next-state, scoreboard and enable decode.
    always_comb begin
        state_next     = state;
        score_l_next   = score_l_q;
        score_r_next   = score_r_q;
        serve_dir_next = serve_dir_q;
        winner_next    = winner_q;

        case (state)
            ST_ATTRACT: begin
                score_l_next = 4'd0;
                score_r_next = 4'd0;
                winner_next  = 2'b00;
                if (start_edge) begin
                    state_next     = ST_SERVE;
                    serve_dir_next = 1'b0;
                end
            end
            ST_SERVE: begin
                if (frame_cnt == SERVE_LIM) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.miss_left && bus.miss_right) begin
                    score_l_next = sat_inc(score_l_q);
                    score_r_next = sat_inc(score_r_q);
                    state_next   = ST_POINT;
                end else if (bus.miss_left) begin
                    score_r_next   = sat_inc(score_r_q);
                    serve_dir_next = 1'b1;
                    state_next     = ST_POINT;
                end else if (bus.miss_right) begin
                    score_l_next   = sat_inc(score_l_q);
                    serve_dir_next = 1'b0;
                    state_next     = ST_POINT;
                end
`ifdef PONG_PAUSE_EN
                else if (pause_edge) begin
                    state_next = ST_PAUSE;
                end
`endif
            end
            ST_POINT: begin
                if (frame_cnt == POINT_LIM) begin
                    if (l_won || r_won) begin
                        state_next  = ST_OVER;
                        winner_next = {r_won, l_won};
                    end else begin
                        state_next = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_next   = ST_ATTRACT;
                    score_l_next = 4'd0;
                    score_r_next = 4'd0;
                    winner_next  = 2'b00;
                end
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (pause_edge) state_next = ST_PLAY;
            end
`endif
            default: begin
                state_next = ST_ATTRACT;
            end
        endcase

        ball_en_next   = (state_next == ST_PLAY);
        paddle_en_next = (state_next == ST_SERVE) || (state_next == ST_PLAY);
    end

    // Renderer select for the current state; latched only on frame_tick.
    always_comb begin
        screen_sel_cur = SEL_START;
        case (state)
            ST_ATTRACT: screen_sel_cur = SEL_START;
            ST_SERVE,
            ST_PLAY,
            ST_POINT:   screen_sel_cur = SEL_FIELD;
            ST_OVER:    screen_sel_cur = SEL_OVER;
`ifdef PONG_PAUSE_EN
            ST_PAUSE:   screen_sel_cur = SEL_PAUSE;
`endif
            default:    screen_sel_cur = SEL_START;
        endcase
    end

    // State, scoreboard, enables, frame counter and button history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_ATTRACT;
            frame_cnt    <= 8'd0;
            start_prev   <= 1'b0;
            pause_prev   <= 1'b0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 2'b00;
            ball_en_q    <= 1'b0;
            paddle_en_q  <= 1'b0;
            screen_sel_q <= SEL_START;
        end else begin
            state       <= state_next;
            start_prev  <= bus.btn_start;
            pause_prev  <= bus.btn_pause;
            score_l_q   <= score_l_next;
            score_r_q   <= score_r_next;
            serve_dir_q <= serve_dir_next;
            winner_q    <= winner_next;
            ball_en_q   <= ball_en_next;
            paddle_en_q <= paddle_en_next;
            // A state entry wins over a coincident tick.
            if (state_next != state) begin
                frame_cnt <= 8'd0;
            end else if (bus.frame_tick && (frame_cnt != 8'hFF)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // Pre-transition state is shown so renderers switch only between frames.
            if (bus.frame_tick) begin
                screen_sel_q <= screen_sel_cur;
            end
        end
    end

    assign bus.screen_sel = screen_sel_q;
    assign bus.ball_en    = ball_en_q;
    assign bus.paddle_en  = paddle_en_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.winner     = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the Pong VGA design. Sequences the display between start, serve, play, point-scored and game-over phases, keeps both players' scores, and drives the enables and screen select that the pixel renderers (start screen, playfield, game-over screen) and the ball/paddle logic consume. Sits beside the VGA timing generator on the pixel clock and advances its timed phases on the generator's once-per-frame tick.

## Interface
- WIN_SCORE, 7, points needed to win; range 1–15.
- SERVE_FRAMES, 60, frames spent in SERVE before the ball launches; range 1–255.
- POINT_FRAMES, 90, frames spent in POINT after a score; range 1–255.

- clk  in  1  pixel clock (the clk_div output); the only clock.
- rst_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, at the start of vertical blank.
- btn_start  in  1  debounced, synchronised start button; level.
- btn_pause  in  1  debounced, synchronised pause button; level. Used only with PONG_PAUSE_EN.
- miss_left  in  1  one-cycle pulse: ball passed the left paddle.
- miss_right  in  1  one-cycle pulse: ball passed the right paddle.
- screen_sel  out  2  renderer select: 00 start, 01 playfield, 10 game over, 11 paused.
- ball_en  out  1  ball motion enable.
- paddle_en  out  1  paddle motion enable.
- serve_dir  out  1  launch direction: 0 rightward, 1 leftward.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- winner  out  2  00 none, 01 left, 10 right, 11 draw.

## Operation
- Rising-edge detection on btn_start and btn_pause: one registered copy of each; edge = level & ~prev.
- States: ATTRACT, SERVE, PLAY, POINT, OVER, plus PAUSE (macro only). 8-bit frame counter, cleared on every state entry, incremented on frame_tick.
- ATTRACT: scores held at 0; winner 00; ball_en=0, paddle_en=0. Start edge → SERVE with serve_dir=0.
- SERVE: ball_en=0, paddle_en=1. When the counter reaches SERVE_FRAMES, go to PLAY.
- PLAY: ball_en=1, paddle_en=1.
  - miss_left: score_r+1, serve_dir←1, go to POINT.
  - miss_right: score_l+1, serve_dir←0, go to POINT.
  - Both in the same cycle: both scores increment, serve_dir unchanged, go to POINT.
- POINT: ball_en=0, paddle_en=0. When the counter reaches POINT_FRAMES:
  - If either score is ≥ WIN_SCORE, go to OVER and set winner (both ≥ gives 11).
  - Otherwise go to SERVE.
- OVER: enables 0; scores and winner held. Start edge → ATTRACT (scores and winner cleared on entry).
- Scores saturate at WIN_SCORE. Miss pulses outside PLAY are ignored. Start edges outside ATTRACT and OVER are ignored.
- screen_sel is derived from the state: ATTRACT→00, SERVE/PLAY/POINT→01, OVER→10, PAUSE→11. It is loaded only on frame_tick, so renderers never switch mid-frame.

## Timing
- Reset (rst_n low at a clk edge): state ATTRACT; screen_sel 00; ball_en 0; paddle_en 0; serve_dir 0; score_l 0; score_r 0; winner 00; frame counter 0; edge-detect registers 0. Reset overrides everything, including mid-game and mid-pause.
- A button edge whose level is high at edge N changes the state at edge N+1. Enables and scores are registered and update on that same edge.
- A miss pulse at edge N: score and state are updated at edge N+1.
- Timed exit: the transition occurs on the edge after the frame_tick that brings the counter to the limit. SERVE lasts exactly SERVE_FRAMES ticks.
- frame_tick in the same cycle as a state change: the counter clears (entry wins), and screen_sel loads the pre-transition state's value.
- screen_sel lags the state by up to one frame.

## Configuration
- PONG_PAUSE_EN defined:
  - btn_pause edge in PLAY → PAUSE with ball_en=0, paddle_en=0, screen_sel 11 at the next frame_tick.
  - btn_pause edge in PAUSE → PLAY.
  - Miss pulses are ignored in PAUSE.
  - btn_pause is ignored in all other states.
- PONG_PAUSE_EN undefined: the PAUSE state does not exist, btn_pause is ignored, and screen_sel never takes the value 11.

## Test plan
- Reset with buttons idle → all outputs at reset values. Press start; after the next frame_tick → screen_sel 01, paddle_en 1, ball_en 0.
- SERVE_FRAMES=3: count 3 frame_ticks after entering SERVE → ball_en 1 exactly one cycle after the third tick, not earlier.
- In PLAY, pulse miss_left → score_r 1, serve_dir 1, ball_en 0. After POINT_FRAMES ticks → back in SERVE.
- WIN_SCORE=2, both miss pulses in the same cycle twice → scores 2/2, winner 11 after POINT. Then a start edge → ATTRACT with scores 0 and screen_sel 00 at the next tick.
- Hold btn_start high continuously through OVER → no restart (edge required). Assert rst_n low mid-PLAY → reset values on the next edge.
- With PONG_PAUSE_EN: pause edge in PLAY → ball_en 0, screen_sel 11. A miss_right pulse while paused leaves score_l unchanged. A second pause edge → ball_en 1.
